zoom_control_decoder: RTL and testbench

- Input-side counterpart of the HEX text-scroller: turns the raw DE1-SoC switches and push-buttons into the `algorithm_select` and error flags that the scroller displays.
- Also tracks the current zoom level and sends a one-cycle request pulse to the scaler datapath.
- Sits between the board I/O pins and both the scaler and the text display.

---
 rtl/zoom_control_decoder.sv | 257 +++++++++++++++++++++++++
 tb/tb_zoom_control_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_control_decoder.sv
// ----------------------------------------------------------------------------
// zoom_control_decoder
//
// Turns the raw DE1-SoC algorithm switches and the two zoom push-buttons into
// the configuration consumed by the scaler datapath and the HEX text scroller.
//
// Every pin goes through a two-flop synchroniser and a per-input debouncer.
// The debounced switches are decoded into an algorithm index and two switch
// error flags. Debounced key presses drive a small IDLE -> EVAL FSM that
// steps zoom_level within the range the current algorithm allows.
//
// Ports
//   clk                       system clock (only clock)
//   reset                     synchronous, active-high reset
//   sw[3:0]                   one-hot algorithm switches (async pins)
//   key_zoom_in_n             zoom-in button, active-low (async pin)
//   key_zoom_out_n            zoom-out button, active-low (async pin)
//   algorithm_select[1:0]     index of the single active switch
//   zoom_level[2:0]           two's-complement level, -MAX_LEVEL..+MAX_LEVEL
//   invalid_zoom_error        last zoom request was rejected
//   multiple_switches_error   more than one switch is on
//   no_switch_selected_error  no switch is on
//   config_pulse              one-cycle strobe: new valid configuration
//
// Handshake: there is no valid/ready pair here. config_pulse is a one-cycle
// strobe, high in exactly the cycle in which the new algorithm_select /
// zoom_level values first appear; consumers sample both on that cycle and
// cannot apply back-pressure.
// ----------------------------------------------------------------------------
module zoom_control_decoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_LEVEL       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       key_zoom_in_n,
    input  logic       key_zoom_out_n,
    output logic [1:0] algorithm_select,
    output logic [2:0] zoom_level,
    output logic       invalid_zoom_error,
    output logic       multiple_switches_error,
    output logic       no_switch_selected_error,
    output logic       config_pulse
);

    localparam int              NUM_INPUTS = 6;
    localparam int              CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Idle level of each input: switches off, keys released (high).
    localparam logic [NUM_INPUTS-1:0] IDLE_LEVELS = 6'b110000;
    localparam logic signed [3:0] MAX_L   = 4'(MAX_LEVEL);

    typedef enum logic {
        ZOOM_IDLE = 1'b0,
        ZOOM_EVAL = 1'b1
    } zoom_state_t;

    // ------------------------------------------------------------------
    // Synchronise and debounce. Bit order: {key_out_n, key_in_n, sw[3:0]}.
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] raw_in;
    logic [NUM_INPUTS-1:0] sync1_q;
    logic [NUM_INPUTS-1:0] sync2_q;
    logic [NUM_INPUTS-1:0] deb_q;
    logic [CNT_W-1:0]      cnt_q [NUM_INPUTS];

    assign raw_in = {key_zoom_out_n, key_zoom_in_n, sw};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= IDLE_LEVELS;
            sync2_q <= IDLE_LEVELS;
            deb_q   <= IDLE_LEVELS;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    // Disagreement has persisted for DEBOUNCE_CYCLES cycles.
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Key press detection: falling edge of the debounced key.
    // ------------------------------------------------------------------
    logic [1:0] key_prev_q;
    logic       press_in;
    logic       press_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_q <= 2'b11;
        end else begin
            key_prev_q <= deb_q[5:4];
        end
    end

    assign press_in  = key_prev_q[0] & ~deb_q[4];
    assign press_out = key_prev_q[1] & ~deb_q[5];

    // ------------------------------------------------------------------
    // Switch decode.
    // ------------------------------------------------------------------
    logic [3:0] sw_deb;
    logic       sw_none;
    logic       sw_multi;
    logic       dec_valid;
    logic [1:0] dec_idx;
    logic       alg_change;

    logic [1:0] alg_q;
    logic       none_q;
    logic       multi_q;
    logic       have_cfg_q;   // a valid index has been decoded since reset

    assign sw_deb = deb_q[3:0];

    always_comb begin
        sw_none   = (sw_deb == 4'b0000);
        // x & (x-1) clears the lowest set bit; non-zero means >= 2 bits set.
        sw_multi  = !sw_none && ((sw_deb & (sw_deb - 4'd1)) != 4'b0000);
        dec_valid = !sw_none && !sw_multi;
        dec_idx   = 2'd0;
        case (sw_deb)
            4'b0010: dec_idx = 2'd1;
            4'b0100: dec_idx = 2'd2;
            4'b1000: dec_idx = 2'd3;
            default: dec_idx = 2'd0;
        endcase
    end

    // Returning to the same index after a switch error is not a change: the
    // level is kept and the latched invalid flag reappears. The very first
    // valid index after reset always counts as a change.
    assign alg_change = dec_valid && (!have_cfg_q || (dec_idx != alg_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            alg_q      <= 2'd0;
            none_q     <= 1'b0;
            multi_q    <= 1'b0;
            have_cfg_q <= 1'b0;
        end else begin
            none_q  <= sw_none;
            multi_q <= sw_multi;
            if (dec_valid) begin
                alg_q      <= dec_idx;
                have_cfg_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Zoom FSM and level register.
    // ------------------------------------------------------------------
    zoom_state_t       state_q;
    zoom_state_t       state_d;
    logic [1:0]        dir_q;       // {zoom_out, zoom_in} captured in IDLE
    logic [1:0]        dir_d;
    logic [2:0]        level_q;
    logic [2:0]        level_d;
    logic              inv_q;       // latched reject flag, masked on output
    logic              inv_d;
    logic              pulse_q;
    logic              pulse_d;
    logic              sw_err_q;
    logic signed [3:0] level_ext;
    logic signed [3:0] target;
    logic signed [3:0] range_lo;
    logic signed [3:0] range_hi;

    assign sw_err_q = none_q | multi_q;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        level_d   = level_q;
        inv_d     = inv_q;
        pulse_d   = 1'b0;
        level_ext = {level_q[2], level_q};
        target    = dir_q[0] ? (level_ext + 4'sd1) : (level_ext - 4'sd1);
        // Enlarging algorithms (00/01) zoom up from 0, reducing ones down.
        range_lo  = alg_q[1] ? -MAX_L : 4'sd0;
        range_hi  = alg_q[1] ? 4'sd0  : MAX_L;

        case (state_q)
            ZOOM_IDLE: begin
                if ((press_in || press_out) && !sw_err_q) begin
                    state_d = ZOOM_EVAL;
                    dir_d   = {press_out, press_in};
                end
            end
            ZOOM_EVAL: begin
                state_d = ZOOM_IDLE;
                // Presses arriving now are dropped; an algorithm change or a
                // switch error appearing this cycle also drops the request.
                if (!alg_change && dec_valid) begin
                    if (dir_q == 2'b11) begin
                        inv_d = 1'b1;
                    end else if ((target >= range_lo) && (target <= range_hi)) begin
                        level_d = target[2:0];
                        inv_d   = 1'b0;
                        pulse_d = 1'b1;
                    end else begin
                        inv_d = 1'b1;
                    end
                end
            end
            default: state_d = ZOOM_IDLE;
        endcase

        if (alg_change) begin
            level_d = 3'd0;
            inv_d   = 1'b0;
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ZOOM_IDLE;
            dir_q   <= 2'b00;
            level_q <= 3'd0;
            inv_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            level_q <= level_d;
            inv_q   <= inv_d;
            pulse_q <= pulse_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Priority: no_switch > multiple > invalid.
    // ------------------------------------------------------------------
    assign algorithm_select         = alg_q;
    assign zoom_level               = level_q;
    assign no_switch_selected_error = none_q;
    assign multiple_switches_error  = multi_q & ~none_q;
    assign invalid_zoom_error       = inv_q & ~sw_err_q;
    assign config_pulse             = pulse_q;

endmodule

// File: tb/tb_zoom_control_decoder.sv
module tb_zoom_control_decoder;

  localparam int DB   = 4;
  localparam int MAXL = 2;

  // clock / reset block
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       key_zoom_in_n;
  logic       key_zoom_out_n;
  logic [1:0] algorithm_select;
  logic [2:0] zoom_level;
  logic       invalid_zoom_error;
  logic       multiple_switches_error;
  logic       no_switch_selected_error;
  logic       config_pulse;

  always #5 clk = ~clk;

  zoom_control_decoder #(
    .DEBOUNCE_CYCLES(DB),
    .MAX_LEVEL(MAXL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .key_zoom_in_n(key_zoom_in_n),
    .key_zoom_out_n(key_zoom_out_n),
    .algorithm_select(algorithm_select),
    .zoom_level(zoom_level),
    .invalid_zoom_error(invalid_zoom_error),
    .multiple_switches_error(multiple_switches_error),
    .no_switch_selected_error(no_switch_selected_error),
    .config_pulse(config_pulse)
  );

  int errors = 0;
  int checks = 0;
  int pulse_count = 0;

  // Reference model: configuration state at transaction level.
  int m_alg, m_level, m_inv, m_none, m_multi, m_have;

  always @(negedge clk) if (config_pulse === 1'b1) pulse_count++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_alg = 0; m_level = 0; m_inv = 0; m_have = 0;
    // debounced switches restart at 0, which decodes as "no switch"
    m_none = 1; m_multi = 0;
  endtask

  // Drive a switch pattern and check the 2+DB+1 cycle latency and result.
  task automatic sw_step(input logic [3:0] pat);
    int pc, idx, exp_pulse, p0;
    logic [2:0] exp_lvl;
    logic exp_inv;
    sw = pat;
    tick(2 + DB);
    checks++;
    if (algorithm_select !== 2'(m_alg) || config_pulse !== 1'b0 ||
        no_switch_selected_error !== 1'(m_none)) begin
      errors++;
      $display("FAIL sw_early: got alg=%0d pulse=%0d none=%0d expected alg=%0d pulse=0 none=%0d",
               algorithm_select, config_pulse, no_switch_selected_error, m_alg, m_none);
    end
    pc = 0; idx = 0; exp_pulse = 0;
    for (int i = 0; i < 4; i++) if (pat[i]) begin pc++; idx = i; end
    m_none  = (pc == 0);
    m_multi = (pc >= 2);
    if (pc == 1) begin
      if (!m_have || idx != m_alg) begin
        m_alg = idx; m_level = 0; m_inv = 0; exp_pulse = 1;
      end
      m_have = 1;
    end
    p0 = pulse_count;
    tick(1);
    exp_lvl = m_level[2:0];
    exp_inv = m_inv && !m_none && !m_multi;
    checks++;
    if (algorithm_select !== 2'(m_alg) || zoom_level !== exp_lvl ||
        invalid_zoom_error !== exp_inv || no_switch_selected_error !== 1'(m_none) ||
        multiple_switches_error !== 1'(m_multi) || config_pulse !== 1'(exp_pulse)) begin
      errors++;
      $display("FAIL sw_result(%b): got alg=%0d lvl=%b inv=%0d none=%0d multi=%0d pulse=%0d expected alg=%0d lvl=%b inv=%0d none=%0d multi=%0d pulse=%0d",
               pat, algorithm_select, zoom_level, invalid_zoom_error, no_switch_selected_error,
               multiple_switches_error, config_pulse, m_alg, exp_lvl, exp_inv, m_none, m_multi, exp_pulse);
    end
    tick(2);
    checks++;
    if (pulse_count - p0 != exp_pulse) begin
      errors++;
      $display("FAIL sw_pulse_count: got %0d expected %0d", pulse_count - p0, exp_pulse);
    end
  endtask

  // kind: 1 = zoom in, 2 = zoom out, 3 = both in the same cycle.
  task automatic press_step(input int kind);
    int exp_pulse, p0, tgt, lo, hi;
    logic [2:0] exp_lvl;
    logic exp_inv;
    exp_lvl = m_level[2:0];
    key_zoom_in_n  = !kind[0];
    key_zoom_out_n = !kind[1];
    tick(2 + DB + 1);
    checks++;
    if (zoom_level !== exp_lvl || config_pulse !== 1'b0) begin
      errors++;
      $display("FAIL press_early: got lvl=%b pulse=%0d expected lvl=%b pulse=0",
               zoom_level, config_pulse, exp_lvl);
    end
    exp_pulse = 0;
    if (!(m_none || m_multi)) begin
      if (kind == 3) begin
        m_inv = 1;
      end else begin
        tgt = m_level + ((kind == 1) ? 1 : -1);
        lo  = (m_alg >= 2) ? -MAXL : 0;
        hi  = (m_alg >= 2) ? 0 : MAXL;
        if (tgt >= lo && tgt <= hi) begin
          m_level = tgt; m_inv = 0; exp_pulse = 1;
        end else begin
          m_inv = 1;
        end
      end
    end
    p0 = pulse_count;
    tick(1);
    exp_lvl = m_level[2:0];
    exp_inv = m_inv && !m_none && !m_multi;
    checks++;
    if (zoom_level !== exp_lvl || invalid_zoom_error !== exp_inv ||
        config_pulse !== 1'(exp_pulse)) begin
      errors++;
      $display("FAIL press_result(kind=%0d): got lvl=%b inv=%0d pulse=%0d expected lvl=%b inv=%0d pulse=%0d",
               kind, zoom_level, invalid_zoom_error, config_pulse, exp_lvl, exp_inv, exp_pulse);
    end
    tick(3);
    key_zoom_in_n  = 1'b1;
    key_zoom_out_n = 1'b1;
    tick(2 + DB + 2);
    checks++;
    if (pulse_count - p0 != exp_pulse || zoom_level !== exp_lvl) begin
      errors++;
      $display("FAIL press_release: got pulses=%0d lvl=%b expected pulses=%0d lvl=%b",
               pulse_count - p0, zoom_level, exp_pulse, exp_lvl);
    end
  endtask

  // Pulse one input away from its level for 1..DB-1 cycles; nothing may change.
  task automatic glitch_step(input int which, input int len);
    int p0;
    logic [1:0] a0;
    logic [2:0] l0;
    logic i0, n0, x0;
    a0 = algorithm_select; l0 = zoom_level; i0 = invalid_zoom_error;
    n0 = no_switch_selected_error; x0 = multiple_switches_error;
    p0 = pulse_count;
    if (which < 4) sw[which] = ~sw[which];
    else if (which == 4) key_zoom_in_n = 1'b0;
    else key_zoom_out_n = 1'b0;
    tick(len);
    if (which < 4) sw[which] = ~sw[which];
    else if (which == 4) key_zoom_in_n = 1'b1;
    else key_zoom_out_n = 1'b1;
    tick(2 + DB + 4);
    checks++;
    if (algorithm_select !== a0 || zoom_level !== l0 || invalid_zoom_error !== i0 ||
        no_switch_selected_error !== n0 || multiple_switches_error !== x0 ||
        pulse_count != p0) begin
      errors++;
      $display("FAIL glitch(in=%0d,len=%0d): got alg=%0d lvl=%b inv=%0d pulses=%0d expected alg=%0d lvl=%b inv=%0d pulses=0",
               which, len, algorithm_select, zoom_level, invalid_zoom_error, pulse_count - p0, a0, l0, i0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sw = 4'b0000; key_zoom_in_n = 1'b1; key_zoom_out_n = 1'b1;
    tick(3);
    checks++;
    if (algorithm_select !== 2'd0 || zoom_level !== 3'd0 || invalid_zoom_error !== 1'b0 ||
        multiple_switches_error !== 1'b0 || no_switch_selected_error !== 1'b0 ||
        config_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got alg=%0d lvl=%b inv=%0d multi=%0d none=%0d pulse=%0d expected all 0",
               algorithm_select, zoom_level, invalid_zoom_error, multiple_switches_error,
               no_switch_selected_error, config_pulse);
    end
    reset = 1'b0;
    model_reset();
    tick(2);
    checks++;
    if (no_switch_selected_error !== 1'b1 || config_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_switch: got none=%0d pulse=%0d expected none=1 pulse=0",
               no_switch_selected_error, config_pulse);
    end
  endtask

  task automatic test_switch_select();
    sw_step(4'b0001);
  endtask

  task automatic test_zoom_enlarge();
    press_step(1);
    press_step(1);
    press_step(1);
  endtask

  task automatic test_zoom_reduce();
    sw_step(4'b0100);
    press_step(2);
    press_step(2);
    press_step(2);
    press_step(1);
  endtask

  task automatic test_switch_errors();
    sw_step(4'b0110);
    press_step(1);
    sw_step(4'b0000);
    press_step(2);
    sw_step(4'b0100);
  endtask

  task automatic test_glitch_and_double();
    glitch_step(1, 3);
    glitch_step(4, 3);
    press_step(3);
    sw_step(4'b0001);
    press_step(1);
    press_step(3);
    sw_step(4'b1001);
    sw_step(4'b0001);
  endtask

  task automatic test_reset_mid();
    sw = 4'b0010;
    tick(3);
    reset = 1'b1;
    tick(1);
    checks++;
    if (algorithm_select !== 2'd0 || zoom_level !== 3'd0 || invalid_zoom_error !== 1'b0 ||
        multiple_switches_error !== 1'b0 || no_switch_selected_error !== 1'b0 ||
        config_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_debounce: got alg=%0d lvl=%b inv=%0d multi=%0d none=%0d pulse=%0d expected all 0",
               algorithm_select, zoom_level, invalid_zoom_error, multiple_switches_error,
               no_switch_selected_error, config_pulse);
    end
    tick(1);
    reset = 1'b0;
    model_reset();
    sw_step(4'b0010);
    press_step(1);
    key_zoom_in_n = 1'b0;
    tick(2 + DB + 1);
    reset = 1'b1;
    key_zoom_in_n = 1'b1;
    tick(1);
    checks++;
    if (zoom_level !== 3'd0 || config_pulse !== 1'b0 || algorithm_select !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_eval: got lvl=%b pulse=%0d alg=%0d expected lvl=000 pulse=0 alg=0",
               zoom_level, config_pulse, algorithm_select);
    end
    tick(1);
    reset = 1'b0;
    model_reset();
    sw_step(4'b0010);
  endtask

  task automatic test_random();
    int op;
    logic [3:0] pat;
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 19);
      if (op < 6) begin
        if ($urandom_range(0, 3) == 0) pat = 4'($urandom_range(0, 15));
        else pat = 4'b0001 << $urandom_range(0, 3);
        sw_step(pat);
      end else if (op < 16) begin
        press_step((op < 15) ? $urandom_range(1, 2) : 3);
      end else if (op < 19) begin
        glitch_step($urandom_range(0, 5), $urandom_range(1, DB - 1));
      end else begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        sw_step(sw);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_switch_select();
    test_zoom_enlarge();
    test_zoom_reduce();
    test_switch_errors();
    test_glitch_and_double();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
